// File: rtl/chi_pkg.sv
// Shared CHI request-node arbiter definitions: command encodings, FSM states
// and the legal-command check.
package chi_pkg;

    localparam logic [3:0] CHI_CMD_READ  = 4'b0001;
    localparam logic [3:0] CHI_CMD_WRITE = 4'b0010;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == CHI_CMD_READ) || (cmd == CHI_CMD_WRITE);
    endfunction

endpackage

// File: rtl/chi_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// above rr_ptr, wrapping at NUM_RN.
module chi_rr_picker #(
    parameter int NUM_RN = 4,
    parameter int PW     = $clog2(NUM_RN)
) (
    input  logic [NUM_RN-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    output logic [PW-1:0]     grant_idx,
    output logic              any
);

    logic [PW-1:0] probe;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        probe     = '0;
        for (int i = 0; i < NUM_RN; i++) begin
            probe = PW'((int'(rr_ptr) + i) % NUM_RN);
            if (!any && req[probe]) begin
                any       = 1'b1;
                grant_idx = probe;
            end
        end
    end

endmodule

// File: rtl/chi_rn_arbiter.sv
// Round-robin arbiter sharing one CHI Home Node channel between NUM_RN request
// nodes; one transaction in flight, with a response timeout.
module chi_rn_arbiter
    import chi_pkg::*;
#(
    parameter int NUM_RN  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RN-1:0]        rn_req_valid,
    output logic [NUM_RN-1:0]        rn_req_ready,
    input  logic [NUM_RN*ADDR_W-1:0] rn_addr,
    input  logic [NUM_RN*4-1:0]      rn_command,
    input  logic [NUM_RN*DATA_W-1:0] rn_write_data,
    output logic [NUM_RN-1:0]        rn_rsp_valid,
    output logic [DATA_W-1:0]        rn_rsp_data,
    output logic                     rn_rsp_err,
    output logic [ADDR_W-1:0]        hn_addr,
    output logic [3:0]               hn_command,
    output logic [DATA_W-1:0]        hn_write_data,
    output logic                     hn_request_valid,
    input  logic [DATA_W-1:0]        hn_read_data,
    input  logic                     hn_response_valid,
    output logic [1:0]               arb_state
);

    localparam int PW = $clog2(NUM_RN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    arb_state_e        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [TW-1:0]     timer;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    logic [ADDR_W-1:0] addr_a  [NUM_RN];
    logic [3:0]        cmd_a   [NUM_RN];
    logic [DATA_W-1:0] wdata_a [NUM_RN];

    always_comb begin
        for (int i = 0; i < NUM_RN; i++) begin
            addr_a[i]  = rn_addr[i*ADDR_W +: ADDR_W];
            cmd_a[i]   = rn_command[i*4 +: 4];
            wdata_a[i] = rn_write_data[i*DATA_W +: DATA_W];
        end
    end

    chi_rr_picker #(.NUM_RN(NUM_RN), .PW(PW)) u_picker (
        .req       (rn_req_valid),
        .rr_ptr    (rr_ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Handshake: a requester holds rn_req_valid with stable payload until it
    // sees rn_req_ready; ready is a one-cycle pulse in IDLE and the payload is
    // captured on that same clock edge. Requests withdrawn earlier are ignored.
    always_comb begin
        rn_req_ready = '0;
        if (!reset && state == ARB_IDLE && pick_any) begin
            rn_req_ready[pick_idx] = 1'b1;
        end
    end

    assign arb_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ARB_IDLE;
            rr_ptr           <= '0;
            gnt_idx          <= '0;
            timer            <= '0;
            rn_rsp_valid     <= '0;
            rn_rsp_data      <= '0;
            rn_rsp_err       <= 1'b0;
            hn_addr          <= '0;
            hn_command       <= '0;
            hn_write_data    <= '0;
            hn_request_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_idx;
                        rr_ptr  <= (pick_idx == PW'(NUM_RN - 1)) ? '0 : pick_idx + 1'b1;
                        if (is_legal_cmd(cmd_a[pick_idx])) begin
                            hn_addr          <= addr_a[pick_idx];
                            hn_command       <= cmd_a[pick_idx];
                            hn_write_data    <= wdata_a[pick_idx];
                            hn_request_valid <= 1'b1;
                            state            <= ARB_ISSUE;
                        end else begin
                            // Illegal command never reaches the Home Node.
                            rn_rsp_valid <= NUM_RN'(1) << pick_idx;
                            rn_rsp_data  <= '0;
                            rn_rsp_err   <= 1'b1;
                            state        <= ARB_RESP;
                        end
                    end
                end
                ARB_ISSUE: begin
                    hn_request_valid <= 1'b0;
                    timer            <= '0;
                    state            <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // A response arriving on the last timer cycle still wins.
                    if (hn_response_valid) begin
                        rn_rsp_valid <= NUM_RN'(1) << gnt_idx;
                        rn_rsp_data  <= (hn_command == CHI_CMD_READ) ? hn_read_data : '0;
                        rn_rsp_err   <= 1'b0;
                        state        <= ARB_RESP;
                    end else if (timer == TIMER_LAST) begin
                        rn_rsp_valid <= NUM_RN'(1) << gnt_idx;
                        rn_rsp_data  <= '0;
                        rn_rsp_err   <= 1'b1;
                        state        <= ARB_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ARB_RESP: begin
                    rn_rsp_valid <= '0;
                    state        <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chi_rn_arbiter.sv
// Self-checking bench for chi_rn_arbiter: table-driven single transactions
// plus directed fairness, timeout and mid-transaction reset sequences.
module tb_chi_rn_arbiter;

    localparam int NUM_RN  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int SW      = NUM_RN + 1 + DATA_W;

    logic                     clk;
    logic                     reset;
    logic [NUM_RN-1:0]        rn_req_valid;
    logic [NUM_RN-1:0]        rn_req_ready;
    logic [NUM_RN*ADDR_W-1:0] rn_addr;
    logic [NUM_RN*4-1:0]      rn_command;
    logic [NUM_RN*DATA_W-1:0] rn_write_data;
    logic [NUM_RN-1:0]        rn_rsp_valid;
    logic [DATA_W-1:0]        rn_rsp_data;
    logic                     rn_rsp_err;
    logic [ADDR_W-1:0]        hn_addr;
    logic [3:0]               hn_command;
    logic [DATA_W-1:0]        hn_write_data;
    logic                     hn_request_valid;
    logic [DATA_W-1:0]        hn_read_data;
    logic                     hn_response_valid;
    logic [1:0]               arb_state;

    chi_rn_arbiter #(
        .NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rn_req_valid      (rn_req_valid),
        .rn_req_ready      (rn_req_ready),
        .rn_addr           (rn_addr),
        .rn_command        (rn_command),
        .rn_write_data     (rn_write_data),
        .rn_rsp_valid      (rn_rsp_valid),
        .rn_rsp_data       (rn_rsp_data),
        .rn_rsp_err        (rn_rsp_err),
        .hn_addr           (hn_addr),
        .hn_command        (hn_command),
        .hn_write_data     (hn_write_data),
        .hn_request_valid  (hn_request_valid),
        .hn_read_data      (hn_read_data),
        .hn_response_valid (hn_response_valid),
        .arb_state         (arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // scoreboard: every response pulse must match the oldest expected one
    always @(negedge clk) begin
        if (rn_rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'({rn_rsp_valid, rn_rsp_err, rn_rsp_data}), 64'(0));
            end else begin
                check("sb_rsp", 64'({rn_rsp_valid, rn_rsp_err, rn_rsp_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // driver tasks
    task automatic set_req(input int rn, input logic [3:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata);
        rn_command[rn*4 +: 4]              = cmd;
        rn_addr[rn*ADDR_W +: ADDR_W]       = addr;
        rn_write_data[rn*DATA_W +: DATA_W] = wdata;
        rn_req_valid[rn]                   = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output logic [NUM_RN-1:0] got);
        got = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rn_req_ready != '0) begin
                got = rn_req_ready;
                break;
            end
        end
    endtask

    task automatic push_exp(input int rn, input logic err, input logic [31:0] data);
        logic [NUM_RN-1:0] oh;
        oh = NUM_RN'(1) << rn;
        exp_q.push_back({oh, err, data});
    endtask

    typedef struct {
        int          rn;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        exp_hn;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        logic [NUM_RN-1:0] oh;
        oh = NUM_RN'(1) << v.rn;
        set_req(v.rn, v.cmd, v.addr, v.wdata);
        push_exp(v.rn, v.exp_err, v.exp_data);
        @(negedge clk);
        check("vec_ready", 64'(rn_req_ready), 64'(oh));
        step();
        rn_req_valid[v.rn] = 1'b0;
        @(negedge clk);
        if (v.exp_hn) begin
            check("vec_hn_valid", 64'(hn_request_valid), 64'(1));
            check("vec_hn_addr", 64'(hn_addr), 64'(v.addr));
            check("vec_hn_cmd", 64'(hn_command), 64'(v.cmd));
            check("vec_hn_wdata", 64'(hn_write_data), 64'(v.wdata));
            for (int k = 1; k <= v.lat; k++) begin
                step();
                if (k == v.lat) begin
                    hn_response_valid = 1'b1;
                    hn_read_data      = v.rdata;
                end
            end
            @(negedge clk);
            check("vec_hn_single_pulse", 64'(hn_request_valid), 64'(0));
            step();
            hn_response_valid = 1'b0;
            hn_read_data      = '0;
            @(negedge clk);
        end else begin
            check("vec_hn_untouched", 64'(hn_request_valid), 64'(0));
        end
        check("vec_rsp_valid", 64'(rn_rsp_valid), 64'(oh));
        check("vec_rsp_err", 64'(rn_rsp_err), 64'(v.exp_err));
        check("vec_rsp_data", 64'(rn_rsp_data), 64'(v.exp_data));
        step();
    endtask

    logic [NUM_RN-1:0] got;
    logic [NUM_RN-1:0] exp_oh;

    initial begin
        vecs[0] = '{1, 4'b0010, 32'h0000_0010, 32'hABCD_1234, 2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1, 4'b0001, 32'h0000_0010, 32'h0,         1, 32'hABCD_1234, 1'b1, 1'b0, 32'hABCD_1234};
        vecs[2] = '{2, 4'b0111, 32'h0000_0020, 32'h1111_1111, 0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[3] = '{3, 4'b0001, 32'hFFFF_FFFC, 32'h0,         3, 32'h5A5A_0001, 1'b1, 1'b0, 32'h5A5A_0001};
        vecs[4] = '{0, 4'b0010, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{2, 4'b0000, 32'h0000_0030, 32'h0,         0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[6] = '{0, 4'b0001, 32'h0000_0044, 32'h0,         8, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D};

        reset             = 1'b1;
        rn_req_valid      = '0;
        rn_addr           = '0;
        rn_command        = '0;
        rn_write_data     = '0;
        hn_read_data      = '0;
        hn_response_valid = 1'b0;

        // all requesters pending from reset
        for (int i = 0; i < NUM_RN; i++) set_req(i, 4'b0001, 32'(i * 256), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(rn_req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rn_rsp_valid), 64'(0));
        check("rst_rsp_data_err", 64'({rn_rsp_err, rn_rsp_data}), 64'(0));
        check("rst_hn", 64'({hn_request_valid, hn_command, hn_addr}), 64'(0));
        check("rst_hn_wdata", 64'(hn_write_data), 64'(0));
        check("rst_state", 64'(arb_state), 64'(0));
        step();
        reset = 1'b0;

        // fairness: expected grant order 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            exp_oh = NUM_RN'(1) << (g % NUM_RN);
            wait_ready(got);
            check("fair_grant", 64'(got), 64'(exp_oh));
            push_exp(g % NUM_RN, 1'b0, 32'hC0DE_0000 + 32'(g % NUM_RN));
            step();
            if (g == 4) rn_req_valid = '0;
            step();
            hn_response_valid = 1'b1;
            hn_read_data      = 32'hC0DE_0000 + 32'(g % NUM_RN);
            step();
            hn_response_valid = 1'b0;
            hn_read_data      = '0;
        end
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // timeout on RN3 with RN1 queued behind it
        set_req(3, 4'b0010, 32'h0000_0080, 32'h0F0F_0F0F);
        push_exp(3, 1'b1, 32'h0);
        @(negedge clk);
        check("to_ready", 64'(rn_req_ready), 64'(4'b1000));
        step();
        rn_req_valid[3] = 1'b0;
        set_req(1, 4'b0001, 32'h0000_0020, 32'h0);
        @(negedge clk);
        check("to_hn_valid", 64'(hn_request_valid), 64'(1));
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            @(negedge clk);
            check("to_wait_no_rsp", 64'(rn_rsp_valid), 64'(0));
            check("to_wait_state", 64'(arb_state), 64'(2));
            check("to_wait_no_grant", 64'(rn_req_ready), 64'(0));
        end
        step();
        @(negedge clk);
        check("to_rsp_valid", 64'(rn_rsp_valid), 64'(4'b1000));
        check("to_rsp_err", 64'(rn_rsp_err), 64'(1));
        check("to_rsp_data", 64'(rn_rsp_data), 64'(0));
        push_exp(1, 1'b0, 32'h0000_0077);
        wait_ready(got);
        check("to_next_grant", 64'(got), 64'(4'b0010));
        step();
        rn_req_valid[1] = 1'b0;
        step();
        hn_response_valid = 1'b1;
        hn_read_data      = 32'h0000_0077;
        step();
        hn_response_valid = 1'b0;
        hn_read_data      = '0;
        @(negedge clk);
        check("to_next_data", 64'(rn_rsp_data), 64'(32'h77));
        step();

        // reset while RN2's read sits in WAIT
        set_req(2, 4'b0001, 32'h0000_002C, 32'h0);
        wait_ready(got);
        check("rw_grant", 64'(got), 64'(4'b0100));
        step();
        rn_req_valid[2] = 1'b0;
        set_req(0, 4'b0001, 32'h0000_0300, 32'h0);
        set_req(3, 4'b0001, 32'h0000_0330, 32'h0);
        @(negedge clk);
        check("rw_hn_valid", 64'(hn_request_valid), 64'(1));
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("rw_ready", 64'(rn_req_ready), 64'(0));
        check("rw_rsp", 64'({rn_rsp_valid, rn_rsp_err, rn_rsp_data}), 64'(0));
        check("rw_hn", 64'({hn_request_valid, hn_command, hn_addr}), 64'(0));
        check("rw_state", 64'(arb_state), 64'(0));
        step();
        reset = 1'b0;
        push_exp(0, 1'b0, 32'h0000_0099);
        @(negedge clk);
        check("rw_post_grant", 64'(rn_req_ready), 64'(4'b0001));
        step();
        rn_req_valid = '0;
        step();
        hn_response_valid = 1'b1;
        hn_read_data      = 32'h0000_0099;
        step();
        hn_response_valid = 1'b0;
        hn_read_data      = '0;
        repeat (4) step();

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
